// File: rtl/cpu_types_pkg.sv
// Shared CPU types plus the scoreboard entry layout and producer latencies.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package cpu_types_pkg;

  localparam int REG_W = 5;
  typedef logic [REG_W-1:0] regbits_t;

  // Width of a per-register forwarding countdown.
  localparam int CNT_W = 2;
  typedef logic [CNT_W-1:0] sbcnt_t;

  // Advancing cycles before a producer's value is forwardable into decode.
  localparam int ALU_LAT  = 1;
  localparam int LOAD_LAT = 2;

  typedef struct packed {
    logic   pending;
    sbcnt_t cnt;
  } sb_entry_t;

  // Countdown step that sticks at zero.
  function automatic sbcnt_t cnt_dec(input sbcnt_t c);
    return (c == '0) ? c : c - sbcnt_t'(1);
  endfunction

endpackage

// File: rtl/scoreboard_hazard_unit_if.sv
// Decode/writeback side of the scoreboard: pipeline control in, stall and perf count out.
// Latency: stall is combinational from the decode fields; the counter is registered.
// Backpressure: stall holds IF/ID and bubbles ID/EX; advance=0 freezes the scoreboard.
interface scoreboard_hazard_unit_if #(
  parameter int PERF_W = 32
);
  logic                    advance;
  logic                    flush;
  logic                    id_valid;
  cpu_types_pkg::regbits_t id_rs;
  cpu_types_pkg::regbits_t id_rt;
  logic                    id_uses_rs;
  logic                    id_uses_rt;
  logic                    id_wen;
  cpu_types_pkg::regbits_t id_wsel;
  logic                    id_is_load;
  logic                    wb_wen;
  cpu_types_pkg::regbits_t wb_wsel;
  logic                    stall;
  logic [PERF_W-1:0]       stall_cycles;

  // Pipeline side: drives decode/writeback info, consumes the stall.
  modport master (
    output advance, flush, id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
           id_wen, id_wsel, id_is_load, wb_wen, wb_wsel,
    input  stall, stall_cycles
  );

  // Hazard unit side.
  modport slave (
    input  advance, flush, id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
           id_wen, id_wsel, id_is_load, wb_wen, wb_wsel,
    output stall, stall_cycles
  );

endinterface

// File: rtl/scoreboard_hazard_unit_sb_entry.sv
// One register's scoreboard state: in-flight write flag and forwarding countdown.
// Latency: updates land on the next CLK edge; ent is the registered state.
// Backpressure: countdown only moves when advance is high; writeback clear ignores advance.
module sb_entry
  import cpu_types_pkg::*;
(
  input  logic      CLK,
  input  logic      nRST,
  input  logic      advance,
  input  logic      alloc,
  input  sbcnt_t    alloc_cnt,
  input  logic      wb_clr,
  input  logic      restore,
  input  sb_entry_t restore_val,
  output sb_entry_t ent
);

  sb_entry_t ent_q;
  sb_entry_t ent_d;

  // Next-state priority, lowest to highest: decrement, restore, writeback, allocate.
  // Writeback beats restore: a retiring older producer has already reached the
  // register file, so the squashed instruction's snapshot must not re-mark it.
  always_comb begin
    ent_d = ent_q;
    if (advance) begin
      ent_d.cnt = cnt_dec(ent_q.cnt);
    end
    if (restore) begin
      ent_d = restore_val;
      if (advance) begin
        ent_d.cnt = cnt_dec(restore_val.cnt);
      end
    end
    if (wb_clr) begin
      ent_d = '0;
    end
    if (alloc) begin
      ent_d.pending = 1'b1;
      ent_d.cnt     = alloc_cnt;
    end
  end

  // Entry state register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ent_q <= '0;
    end else begin
      ent_q <= ent_d;
    end
  end

  assign ent = ent_q;

endmodule

// File: rtl/scoreboard_hazard_unit.sv
// Producer-side scoreboard: tracks in-flight register writes and stalls decode on unforwardable sources.
// Latency: stall is combinational from decode fields; scoreboard updates take effect next CLK edge.
// Backpressure: advance=0 freezes all countdowns; stall gates issue; flush undoes the last allocation.
module scoreboard_hazard_unit #(
  parameter int NREGS    = 32,
  parameter int ALU_LAT  = cpu_types_pkg::ALU_LAT,
  parameter int LOAD_LAT = cpu_types_pkg::LOAD_LAT,
  parameter int PERF_W   = 32
) (
  input  logic                     CLK,
  input  logic                     nRST,
  scoreboard_hazard_unit_if.slave  sb
);
  import cpu_types_pkg::*;

  sb_entry_t         ent [NREGS];
  logic              stall_w;
  logic              rs_hold;
  logic              rt_hold;
  logic              issue;
  logic              do_alloc;
  sbcnt_t            alloc_cnt;

  // Snapshot of the entry overwritten by the most recent allocation, so a
  // flush of that instruction can put the older producer's state back.
  logic              last_vld;
  regbits_t          last_wsel;
  sb_entry_t         last_snap;

  logic [PERF_W-1:0] perf_q;

  // Register 0 is hardwired zero and never has an in-flight write.
  assign ent[0] = '0;

  // A source holds decode while its producer's countdown has not reached zero.
  always_comb begin
    rs_hold = sb.id_uses_rs && ent[sb.id_rs].pending && (ent[sb.id_rs].cnt != '0);
    rt_hold = sb.id_uses_rt && ent[sb.id_rt].pending && (ent[sb.id_rt].cnt != '0);
    stall_w = sb.id_valid && (rs_hold || rt_hold);
  end

  // Issue and allocation decode for this cycle.
  always_comb begin
    issue     = sb.advance && sb.id_valid && !stall_w && !sb.flush;
    do_alloc  = issue && sb.id_wen && (sb.id_wsel != '0);
    alloc_cnt = sb.id_is_load ? sbcnt_t'(LOAD_LAT) : sbcnt_t'(ALU_LAT);
  end

  for (genvar r = 1; r < NREGS; r++) begin : g_ent
    sb_entry u_ent (
      .CLK         (CLK),
      .nRST        (nRST),
      .advance     (sb.advance),
      .alloc       (do_alloc && (sb.id_wsel == regbits_t'(r))),
      .alloc_cnt   (alloc_cnt),
      .wb_clr      (sb.wb_wen && (sb.wb_wsel == regbits_t'(r))),
      .restore     (sb.flush && last_vld && (last_wsel == regbits_t'(r))),
      .restore_val (last_snap),
      .ent         (ent[r])
    );
  end

  // Track the last allocation; it stays undoable only until the next advancing cycle.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      last_vld  <= 1'b0;
      last_wsel <= '0;
      last_snap <= '0;
    end else if (sb.flush) begin
      last_vld <= 1'b0;
    end else if (do_alloc) begin
      last_vld  <= 1'b1;
      last_wsel <= sb.id_wsel;
      last_snap <= ent[sb.id_wsel];
    end else if (sb.advance) begin
      last_vld <= 1'b0;
    end
  end

  // Saturating count of cycles decode spent stalled while the pipe was moving.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      perf_q <= '0;
    end else if (stall_w && sb.advance && (perf_q != '1)) begin
      perf_q <= perf_q + {{(PERF_W-1){1'b0}}, 1'b1};
    end
  end

  assign sb.stall        = stall_w;
  assign sb.stall_cycles = perf_q;

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Directed bench for the scoreboard hazard unit with hand-computed expectations.
// Latency: inputs driven 1 time unit after each rising edge, outputs sampled 1 unit later.
// Backpressure: exercises advance=0 freezes, flush restore and counter saturation.
module tb_scoreboard_hazard_unit;

  localparam int PW = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  scoreboard_hazard_unit_if #(.PERF_W(PW)) sbif ();

  scoreboard_hazard_unit #(
    .NREGS    (32),
    .ALU_LAT  (1),
    .LOAD_LAT (2),
    .PERF_W   (PW)
  ) dut (
    .CLK  (clk),
    .nRST (rst_n),
    .sb   (sbif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic idle;
    sbif.advance    = 1'b1;
    sbif.flush      = 1'b0;
    sbif.id_valid   = 1'b0;
    sbif.id_rs      = '0;
    sbif.id_rt      = '0;
    sbif.id_uses_rs = 1'b0;
    sbif.id_uses_rt = 1'b0;
    sbif.id_wen     = 1'b0;
    sbif.id_wsel    = '0;
    sbif.id_is_load = 1'b0;
    sbif.wb_wen     = 1'b0;
    sbif.wb_wsel    = '0;
  endtask

  task automatic dec(input logic v, input logic [4:0] rs, input logic urs,
                     input logic [4:0] rt, input logic urt,
                     input logic wen, input logic [4:0] ws, input logic ld);
    sbif.id_valid   = v;
    sbif.id_rs      = rs;
    sbif.id_uses_rs = urs;
    sbif.id_rt      = rt;
    sbif.id_uses_rt = urt;
    sbif.id_wen     = wen;
    sbif.id_wsel    = ws;
    sbif.id_is_load = ld;
  endtask

  task automatic wb(input logic [4:0] r);
    sbif.wb_wen  = 1'b1;
    sbif.wb_wsel = r;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle();
    dec(1, 4, 1, 4, 1, 0, 0, 0);
    #3;
    check("rst_stall", sbif.stall, 0);
    check("rst_perf", sbif.stall_cycles, 0);
    #10 rst_n = 1'b1;

    // ALU result consumed back-to-back: one stall cycle.
    tick; idle(); dec(1, 0, 0, 0, 0, 1, 3, 0); settle;
    check("alu_issue_stall", sbif.stall, 0);
    tick; idle(); dec(1, 3, 1, 0, 0, 0, 0, 0); settle;
    check("alu_raw_stall", sbif.stall, 1);
    tick; idle(); dec(1, 3, 1, 0, 0, 0, 0, 0); settle;
    check("alu_raw_clear", sbif.stall, 0);
    check("alu_perf", sbif.stall_cycles, 1);
    tick; idle(); wb(3);

    // Load-use with a three-cycle memory freeze in the middle.
    tick; idle(); dec(1, 0, 0, 0, 0, 1, 5, 1); settle;
    check("ld_issue_stall", sbif.stall, 0);
    tick; idle(); dec(1, 0, 0, 5, 1, 0, 0, 0); settle;
    check("ld_use_stall1", sbif.stall, 1);
    for (int i = 0; i < 3; i++) begin
      tick; idle(); dec(1, 0, 0, 5, 1, 0, 0, 0); sbif.advance = 1'b0; settle;
      check("ld_freeze_stall", sbif.stall, 1);
      check("ld_freeze_perf", sbif.stall_cycles, 2);
    end
    tick; idle(); dec(1, 0, 0, 5, 1, 0, 0, 0); settle;
    check("ld_use_stall2", sbif.stall, 1);
    tick; idle(); dec(1, 0, 0, 5, 1, 0, 0, 0); settle;
    check("ld_use_clear", sbif.stall, 0);
    check("ld_perf", sbif.stall_cycles, 3);
    tick; idle(); wb(5);

    // Writes to register 0 never create a hazard.
    tick; idle(); dec(1, 0, 0, 0, 0, 1, 0, 1); settle;
    tick; idle(); dec(1, 0, 1, 0, 1, 0, 0, 0); settle;
    check("r0_no_stall", sbif.stall, 0);

    // Writeback and a new load to the same register in one cycle: load wins.
    tick; idle(); dec(1, 0, 0, 0, 0, 1, 7, 1); wb(7); settle;
    check("coll_issue_stall", sbif.stall, 0);
    tick; idle(); dec(1, 7, 1, 0, 0, 0, 0, 0); settle;
    check("coll_stall1", sbif.stall, 1);
    tick; idle(); dec(1, 7, 1, 0, 0, 0, 0, 0); settle;
    check("coll_stall2", sbif.stall, 1);
    tick; idle(); dec(1, 7, 1, 0, 0, 0, 0, 0); settle;
    check("coll_clear", sbif.stall, 0);
    check("coll_perf", sbif.stall_cycles, 5);
    tick; idle(); wb(7);

    // Flush of a load over a clean register leaves it clean.
    tick; idle(); dec(1, 0, 0, 0, 0, 1, 9, 1); settle;
    tick; idle(); sbif.flush = 1'b1; settle;
    tick; idle(); dec(1, 9, 1, 0, 0, 0, 0, 0); settle;
    check("flush_clean", sbif.stall, 0);

    // Flush over an older ALU producer at cnt=1, advancing: restored and decremented to 0.
    tick; idle(); dec(1, 0, 0, 0, 0, 1, 9, 0); settle;
    tick; idle(); dec(1, 0, 0, 0, 0, 1, 9, 1); settle;
    check("flush_over_issue", sbif.stall, 0);
    tick; idle(); sbif.flush = 1'b1; settle;
    tick; idle(); dec(1, 9, 1, 0, 0, 0, 0, 0); settle;
    check("flush_restore_adv", sbif.stall, 0);

    // Same, but the flush cycle is frozen: older producer's cnt=1 comes back intact.
    tick; idle(); dec(1, 0, 0, 0, 0, 1, 9, 0); settle;
    tick; idle(); dec(1, 0, 0, 0, 0, 1, 9, 1); settle;
    tick; idle(); sbif.flush = 1'b1; sbif.advance = 1'b0; settle;
    tick; idle(); dec(1, 9, 1, 0, 0, 0, 0, 0); settle;
    check("flush_restore_frz", sbif.stall, 1);
    tick; idle(); dec(1, 9, 1, 0, 0, 0, 0, 0); settle;
    check("flush_restore_clr", sbif.stall, 0);
    check("flush_perf", sbif.stall_cycles, 6);

    // A stale snapshot (an advancing cycle already passed) must not be restored.
    tick; idle(); dec(1, 0, 0, 0, 0, 1, 10, 1); settle;
    tick; idle(); settle;
    tick; idle(); sbif.flush = 1'b1; sbif.advance = 1'b0; settle;
    tick; idle(); dec(1, 10, 1, 0, 0, 0, 0, 0); settle;
    check("stale_flush_stall", sbif.stall, 1);
    tick; idle(); dec(1, 10, 1, 0, 0, 0, 0, 0); settle;
    check("stale_flush_clr", sbif.stall, 0);
    check("stale_perf", sbif.stall_cycles, 7);

    // Asynchronous reset mid-cycle with $4 pending.
    tick; idle(); dec(1, 0, 0, 0, 0, 1, 4, 1); settle;
    tick; idle(); dec(1, 4, 1, 0, 0, 0, 0, 0); settle;
    check("pre_reset_stall", sbif.stall, 1);
    check("pre_reset_perf", sbif.stall_cycles, 7);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_stall", sbif.stall, 0);
    check("async_rst_perf", sbif.stall_cycles, 0);
    #2 rst_n = 1'b1;
    tick; settle;
    check("post_reset_stall", sbif.stall, 0);

    // Drive load-use pairs until the 4-bit counter saturates at 0xF.
    for (int it = 0; it < 10; it++) begin
      tick; idle(); dec(1, 0, 0, 0, 0, 1, 4, 1); settle;
      check("sat_perf", sbif.stall_cycles, (2 * it > 15) ? 15 : 2 * it);
      tick; idle(); dec(1, 4, 1, 0, 0, 0, 0, 0); settle;
      tick; idle(); dec(1, 4, 1, 0, 0, 0, 0, 0); settle;
    end
    tick; idle(); settle;
    check("sat_final", sbif.stall_cycles, 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
